pll_reset_sequencer: RTL

- Controls the core PLL (74.25 MHz ref in; 57.27/14.32/7.16/12.27 MHz outputs; active-high reset; lock output) from the always-running 74.25 MHz domain.
- Pulses the PLL reset, waits for lock with a timeout, retries a bounded number of times, then qualifies lock over a stability window.
- Only after that does it release the core reset and flag the generated clocks as usable.
- Re-sequences on loss of lock or on a software relock request.

---
 rtl/pll_reset_sequencer_if.sv | 38 +++
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Control and status bundle between the PLL reset sequencer (master) and the
// PLL / system side (slave).
interface pll_reset_sequencer_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  logic          pll_locked_raw;
  logic          relock_req;
  logic          pll_rst;
  logic          pll_ready;
  logic          core_reset_n;
  logic          fail;
  logic [RW-1:0] retry_count;
  logic [2:0]    state_o;

  modport master (
    input  pll_locked_raw,
    input  relock_req,
    output pll_rst,
    output pll_ready,
    output core_reset_n,
    output fail,
    output retry_count,
    output state_o
  );

  modport slave (
    output pll_locked_raw,
    output relock_req,
    input  pll_rst,
    input  pll_ready,
    input  core_reset_n,
    input  fail,
    input  retry_count,
    input  state_o
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Brings the core PLL up from the free-running 74.25 MHz domain: pulse reset,
// wait for lock with bounded retries, qualify lock, then release core reset.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 74250,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  pll_reset_sequencer_if.master bus
);

  localparam int MAX_AB  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RW      = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             fail_q, fail_d;
  logic             pll_rst_q, pll_ready_q, core_reset_n_q;
  logic [1:0]       sync_q;
  logic             lock_s;

  // pll_locked_raw comes straight off the PLL with no relation to clk_74a.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], bus.pll_locked_raw};
    end
  end

  assign lock_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fail_d  = fail_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_RESET_PLL;
            retry_d = retry_q + RW'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABILIZE: begin
        // Any dropout restarts the lock wait from scratch without costing a retry.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // A relock request wins over anything else, except while the PLL reset is already being pulsed.
    if (bus.relock_req && (state_q != ST_RESET_PLL)) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
      fail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RESET_PLL;
      cnt_q          <= '0;
      retry_q        <= '0;
      fail_q         <= 1'b0;
      pll_rst_q      <= 1'b1;
      pll_ready_q    <= 1'b0;
      core_reset_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      fail_q         <= fail_d;
      pll_rst_q      <= (state_d == ST_RESET_PLL);
      pll_ready_q    <= (state_d == ST_RUN);
      core_reset_n_q <= (state_d == ST_RUN);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.pll_ready    = pll_ready_q;
  assign bus.core_reset_n = core_reset_n_q;
  assign bus.fail         = fail_q;
  assign bus.retry_count  = retry_q;
  assign bus.state_o      = state_q;

endmodule
